// File: rtl/keypad_scan_encoder_if.sv
// keypad_scan_encoder_if: keypad pins plus the keyboard_data/IsPressed/key_event bundle.
// Revision: 1.0
`default_nettype none

interface keypad_scan_encoder_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keyboard_data;
  logic       IsPressed;
  logic       key_event;

  modport master (
    input  row_in,
    output col_out, keyboard_data, IsPressed, key_event
  );

  modport slave (
    output row_in,
    input  col_out, keyboard_data, IsPressed, key_event
  );
endinterface

`default_nettype wire

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 active-low keypad, debounces full-scan results and commits one key.
// Revision: 1.0
`default_nettype none

module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic                   clk,
  input  logic                   sys_rst_n,
  keypad_scan_encoder_if.master  kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    CAND_NONE    = 2'd0,
    CAND_KEY     = 2'd1,
    CAND_INVALID = 2'd2
  } cand_kind_e;

  logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_out_q, col_out_d;
  logic [15:0]   sample_q, sample_d;
  logic          eval_q, eval_d;
  cand_kind_e    kind_q, kind_d;
  logic [3:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    data_q, data_d;
  logic          pressed_q, pressed_d;
  logic          event_q, event_d;

  cand_kind_e    new_kind;
  logic [3:0]    new_code;
  logic [4:0]    low_cnt;
  logic [3:0]    low_idx;
  logic          commit;

  // Sample index is col*4+row.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'h1;
      4'd1:    key_code = 4'h4;
      4'd2:    key_code = 4'h7;
      4'd3:    key_code = 4'hE;
      4'd4:    key_code = 4'h2;
      4'd5:    key_code = 4'h5;
      4'd6:    key_code = 4'h8;
      4'd7:    key_code = 4'h0;
      4'd8:    key_code = 4'h3;
      4'd9:    key_code = 4'h6;
      4'd10:   key_code = 4'h9;
      4'd11:   key_code = 4'hF;
      4'd12:   key_code = 4'hA;
      4'd13:   key_code = 4'hB;
      4'd14:   key_code = 4'hC;
      default: key_code = 4'hD;
    endcase
  endfunction

  always_comb begin
    row_s1_d  = kp.row_in;
    row_s2_d  = row_s1_q;
    dwell_d   = dwell_q + 1'b1;
    col_d     = col_q;
    sample_d  = sample_q;
    eval_d    = 1'b0;
    if (dwell_q == DWELL_LAST) begin
      dwell_d  = '0;
      col_d    = col_q + 2'd1;
      sample_d[{col_q, 2'b00} +: 4] = row_s2_q;
      eval_d   = (col_q == 2'd3);
    end
    col_out_d = ~(4'b0001 << col_d);

    low_cnt = 5'd0;
    low_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!sample_q[i]) begin
        low_cnt = low_cnt + 5'd1;
        low_idx = 4'(i);
      end
    end
    if (low_cnt == 5'd0) begin
      new_kind = CAND_NONE;
      new_code = 4'h0;
    end else if (low_cnt == 5'd1) begin
      new_kind = CAND_KEY;
      new_code = key_code(low_idx);
    end else begin
      new_kind = CAND_INVALID;
      new_code = 4'h0;
    end

    kind_d    = kind_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    pressed_d = pressed_q;
    event_d   = 1'b0;
    commit    = 1'b0;
    if (eval_q) begin
      if (new_kind == CAND_INVALID) begin
        kind_d = CAND_INVALID;
        cnt_d  = '0;
      end else if (new_kind == kind_q && new_code == code_q) begin
        // Saturated counter means this candidate already committed.
        if (cnt_q < CNT_MAX) begin
          cnt_d  = cnt_q + CNT_ONE;
          commit = ((cnt_q + CNT_ONE) == CNT_MAX);
        end
      end else begin
        kind_d = new_kind;
        code_d = new_code;
        cnt_d  = CNT_ONE;
        commit = (CNT_ONE == CNT_MAX);
      end
      if (commit) begin
        if (new_kind == CAND_KEY) begin
          data_d    = new_code;
          pressed_d = 1'b1;
          event_d   = !pressed_q || (new_code != data_q);
        end else begin
          pressed_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      dwell_q   <= '0;
      col_q     <= 2'd0;
      col_out_q <= 4'b1110;
      sample_q  <= 16'hFFFF;
      eval_q    <= 1'b0;
      kind_q    <= CAND_NONE;
      code_q    <= 4'h0;
      cnt_q     <= '0;
      data_q    <= 4'h0;
      pressed_q <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      row_s1_q  <= row_s1_d;
      row_s2_q  <= row_s2_d;
      dwell_q   <= dwell_d;
      col_q     <= col_d;
      col_out_q <= col_out_d;
      sample_q  <= sample_d;
      eval_q    <= eval_d;
      kind_q    <= kind_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      pressed_q <= pressed_d;
      event_q   <= event_d;
    end
  end

  assign kp.col_out       = col_out_q;
  assign kp.keyboard_data = data_q;
  assign kp.IsPressed     = pressed_q;
  assign kp.key_event     = event_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder: directed bench with a keypad model driving row_in from col_out.
// Revision: 1.0
`default_nettype none

module tb_keypad_scan_encoder;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [15:0] keys;        // bit r*4+c pressed
  int          checks   = 0;
  int          failures = 0;
  int          ev_cnt   = 0;

  always #5 clk = ~clk;

  keypad_scan_encoder_if kif ();

  keypad_scan_encoder #(
    .SCAN_DIV       (8),
    .DEBOUNCE_SCANS (3)
  ) u_dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .kp        (kif.master)
  );

  assign kif.row_in = {~|(keys[15:12] & ~kif.col_out),
                       ~|(keys[11:8]  & ~kif.col_out),
                       ~|(keys[7:4]   & ~kif.col_out),
                       ~|(keys[3:0]   & ~kif.col_out)};

  always @(negedge clk) begin
    if (kif.key_event === 1'b1) ev_cnt <= ev_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] data, input logic pr, input logic ev);
    check({tag, "_data"},    16'(kif.keyboard_data), 16'(data));
    check({tag, "_pressed"}, 16'(kif.IsPressed),     16'(pr));
    check({tag, "_event"},   16'(kif.key_event),     16'(ev));
  endtask

  // Advances from one post-evaluation sample point to the n-th next one.
  task automatic next_scan(input int n);
    repeat (32 * n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    keys      = 16'h0000;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 16'(kif.col_out), 16'hE);
    check_outs("rst", 4'h0, 1'b0, 1'b0);

    sys_rst_n = 1'b1;
    repeat (8) @(posedge clk); @(negedge clk);
    check("rot_8", 16'(kif.col_out), 16'hD);
    repeat (8) @(posedge clk); @(negedge clk);
    check("rot_16", 16'(kif.col_out), 16'hB);
    repeat (8) @(posedge clk); @(negedge clk);
    check("rot_24", 16'(kif.col_out), 16'h7);
    repeat (8) @(posedge clk); @(negedge clk);
    check("rot_32", 16'(kif.col_out), 16'hE);
    check_outs("rot", 4'h0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);

    keys = 16'h0002;                 // r0c1 -> code 2
    next_scan(2);
    check_outs("press_e2", 4'h0, 1'b0, 1'b0);
    next_scan(1);
    check_outs("press_e3", 4'h2, 1'b1, 1'b1);

    keys = 16'h0000;
    next_scan(2);
    check_outs("rel_e2", 4'h2, 1'b1, 1'b0);
    next_scan(1);
    check_outs("rel_e3", 4'h2, 1'b0, 1'b0);
    check("ev_after_press", 16'(ev_cnt), 16'd1);

    keys = 16'h0010;                 // r1c0 bouncing
    next_scan(2);
    keys = 16'h0000;
    next_scan(1);
    keys = 16'h0010;
    next_scan(2);
    check_outs("bounce", 4'h2, 1'b0, 1'b0);
    keys = 16'h0000;
    next_scan(1);
    check("ev_after_bounce", 16'(ev_cnt), 16'd1);

    keys = 16'h0801;                 // r0c0 + r2c3
    next_scan(6);
    check_outs("multi", 4'h2, 1'b0, 1'b0);
    keys = 16'h0001;
    next_scan(2);
    check_outs("multi_rel_e2", 4'h2, 1'b0, 1'b0);
    next_scan(1);
    check_outs("multi_rel_e3", 4'h1, 1'b1, 1'b1);

    keys = 16'h0008;                 // r0c3 -> code A
    next_scan(1);
    check_outs("k2k_e1", 4'h1, 1'b1, 1'b0);
    check("ev_after_multi", 16'(ev_cnt), 16'd2);
    next_scan(1);
    check_outs("k2k_e2", 4'h1, 1'b1, 1'b0);
    next_scan(1);
    check_outs("k2k_e3", 4'hA, 1'b1, 1'b1);

    keys = 16'h4000;                 // r3c2 -> code F
    next_scan(2);
    repeat (5) @(negedge clk);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_col", 16'(kif.col_out), 16'hE);
    check_outs("mid_rst", 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    next_scan(2);
    check_outs("post_rst_e2", 4'h0, 1'b0, 1'b0);
    check("ev_before_f", 16'(ev_cnt), 16'd3);
    next_scan(1);
    check_outs("post_rst_e3", 4'hF, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    check("ev_final", 16'(ev_cnt), 16'd4);
    check("event_one_cycle", 16'(kif.key_event), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
